// File: rtl/bus_master_cmd_queue.sv
// Command FIFO feeding a hold/execute/completion/release issuer on the bus master port.
// Define BUS_CMDQ_TIMEOUT_EN to compile in the EXEC watchdog abort.
module bus_master_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        C_VALID,
   output logic        C_READY,
   input  logic [15:0] C_ADDR,
   input  logic        C_RW,
   input  logic [7:0]  C_WDATA,
   output logic        R_VALID,
   output logic        R_RW,
   output logic [7:0]  R_RDATA,
   output logic        R_ERR,
   output logic        M_HOLD,
   output logic        M_EXECUTE,
   output logic [15:0] M_ADDR,
   output logic        M_RW,
   output logic [7:0]  M_DIN,
   input  logic        M_DVALID,
   input  logic [7:0]  M_DOUT,
   input  logic        M_BSY
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HOLD    = 2'd1;
   localparam logic [1:0] EXEC    = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   generate
      if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
          GAP < 1 || GAP > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
         $error("bus_master_cmd_queue: parameter out of range");
      end
   endgenerate

   logic [24:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [1:0]    state;
   logic [3:0]    gap_cnt;
   logic [24:0]   head;
   logic          push;
   logic          pop;
   logic          done;
   logic          abort;

   assign C_READY   = (count != FULL);
   assign push      = C_VALID && C_READY;
   assign head      = mem[rd_ptr];
   assign done      = (state == EXEC) && M_DVALID;
   assign pop       = done || abort;
   assign M_HOLD    = (state == HOLD) || (state == EXEC);
   assign M_EXECUTE = (state == EXEC);

`ifdef BUS_CMDQ_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wd;

   // A completion arriving on the terminal watchdog edge takes priority over the abort.
   assign abort = (state == EXEC) && !M_DVALID && (wd == WD_LAST);

   always_ff @(posedge CLK) begin
      if (RST)
         wd <= '0;
      else if (state == HOLD)
         wd <= '0;
      else if (state == EXEC)
         wd <= wd + 8'd1;
   end
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= {C_ADDR, C_RW, C_WDATA};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         gap_cnt <= '0;
         M_ADDR  <= '0;
         M_RW    <= 1'b0;
         M_DIN   <= '0;
         R_VALID <= 1'b0;
         R_RW    <= 1'b0;
         R_RDATA <= '0;
         R_ERR   <= 1'b0;
      end else begin
         R_VALID <= pop;
         if (pop) begin
            R_RW    <= M_RW;
            R_RDATA <= (done && !M_RW) ? M_DOUT : 8'h00;
            R_ERR   <= abort;
         end
         case (state)
            IDLE: begin
               if (count != '0 && !M_BSY) begin
                  state  <= HOLD;
                  M_ADDR <= head[24:9];
                  M_RW   <= head[8];
                  // Reads leave M_DIN at whatever the last write drove.
                  if (head[8])
                     M_DIN <= head[7:0];
               end
            end
            HOLD:
               state <= EXEC;
            EXEC: begin
               if (pop) begin
                  state   <= RELEASE;
                  gap_cnt <= GAP_LAST;
               end
            end
            default: begin
               if (gap_cnt == 4'd0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 4'd1;
            end
         endcase
      end
   end
endmodule

// File: doc/bus_master_cmd_queue.md
# bus_master_cmd_queue

Command queue and issue sequencer directly upstream of the bus master interface. Buffers host read/write commands in a small FIFO and plays each one onto the master port using the hold → execute → completion → release sequence. It returns one response per command: read data, or write acknowledge. An optional watchdog aborts transactions the master never completes.

## Interface
Parameters:
- DEPTH, 4 — command FIFO entries; power of two, 2..16
- GAP, 2 — idle cycles between dropping M_HOLD and starting the next command; 1..15
- TIMEOUT, 255 — EXEC cycles before abort (only with watchdog compiled in); 1..255

Ports (clock and reset first):
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- C_VALID  in  1  host command valid
- C_READY  out  1  queue can accept a command
- C_ADDR  in  16  command address
- C_RW  in  1  1 = write, 0 = read
- C_WDATA  in  8  write data (ignored for reads)
- R_VALID  out  1  one-cycle response pulse; no backpressure
- R_RW  out  1  direction of the completed command
- R_RDATA  out  8  read data (0 for writes and aborts)
- R_ERR  out  1  command aborted by watchdog
- M_HOLD  out  1  bus request to master
- M_EXECUTE  out  1  start/hold transaction
- M_ADDR  out  16  transaction address
- M_RW  out  1  transaction direction
- M_DIN  out  8  write data to master
- M_DVALID  in  1  master completion pulse; M_DOUT valid when read
- M_DOUT  in  8  read data from master
- M_BSY  in  1  master/bus busy

## Operation
- FIFO holds {addr, rw, wdata}, 25 bits per entry. Count width is clog2(DEPTH)+1.
- C_READY = (count != DEPTH); combinational from count only.
- A push occurs on an edge where C_VALID && C_READY. A pop occurs only on the issuer's completion or abort edge.
- Simultaneous push and pop leaves count unchanged. A push while full is impossible because C_READY is low. Pointers wrap modulo DEPTH.
- Issuer FSM states: IDLE, HOLD, EXEC, RELEASE.
- IDLE → HOLD when FIFO not empty and M_BSY = 0. On that edge, M_ADDR/M_RW/M_DIN load from the FIFO head. For reads, M_DIN is held at its previous value.
- HOLD: M_HOLD = 1, M_EXECUTE = 0. Exactly one cycle, then → EXEC.
- EXEC: M_HOLD = 1, M_EXECUTE = 1. M_ADDR/M_RW/M_DIN stay stable.
  - On an edge with M_DVALID = 1: capture M_DOUT if read, pop, → RELEASE.
- RELEASE: M_HOLD = M_EXECUTE = 0 for GAP cycles (counter), then → IDLE.
- Response: registered. R_VALID is high for exactly the cycle after the completion or abort edge.
  - R_RW = command direction.
  - R_RDATA = captured M_DOUT for reads, else 0.
- M_DVALID outside EXEC is ignored.
- M_BSY is sampled only in IDLE.

## Timing
- Reset values: C_READY = 1 (after reset edge), R_VALID = R_RW = R_ERR = 0, R_RDATA = 0, M_HOLD = M_EXECUTE = 0, M_ADDR = 0, M_RW = 0, M_DIN = 0. FSM = IDLE, FIFO empty.
- Push into an empty FIFO on edge 0, with M_BSY low:
  - edge 1: IDLE→HOLD; M_HOLD high after edge 1.
  - edge 2: M_EXECUTE high after edge 2.
- M_DVALID sampled at edge k: M_HOLD/M_EXECUTE low and R_VALID high after edge k; R_VALID low after edge k+1.
- Earliest next M_HOLD is after edge k+GAP+1, with the IDLE check on edge k+GAP+1.
- Back-to-back commands never overlap. At least GAP cycles with M_HOLD low separate transactions.
- RST mid-transaction: on the reset edge, all outputs return to reset values and the FIFO is flushed. No response is produced for flushed or in-flight commands.

## Configuration
- BUS_CMDQ_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entering EXEC and increments each EXEC cycle.
  - On the edge where it equals TIMEOUT-1 and M_DVALID = 0: abort, pop, → RELEASE. R_VALID = 1 with R_ERR = 1 and R_RDATA = 0.
  - M_DVALID on that same edge wins: normal completion, R_ERR = 0.
- Undefined: no watchdog logic. EXEC waits indefinitely and R_ERR is tied 0.

## Test plan
- Single write: push addr 0x1234, wdata 0xAD, rw = 1; M_DVALID pulses 30 cycles after M_EXECUTE rises → M_ADDR = 0x1234, M_DIN = 0xAD stable throughout EXEC; R_VALID one cycle with R_RW = 1, R_RDATA = 0x00.
- Single read: push addr 0x00F0, rw = 0; M_DVALID with M_DOUT = 0x5C → R_RDATA = 0x5C, R_RW = 0; M_HOLD low for ≥ GAP = 2 cycles afterwards.
- Fill and drain: push 5 commands with DEPTH = 4 and the master stalled → C_READY low after 4th push; 5th accepted in the cycle after first completion; responses return in push order.
- Bus busy gate: M_BSY held high for 10 cycles with FIFO non-empty → M_HOLD stays 0; HOLD entered the edge after M_BSY falls.
- Watchdog (TIMEOUT_EN, TIMEOUT = 20): no M_DVALID → abort after 20 EXEC cycles, R_ERR = 1, R_RDATA = 0; a later late M_DVALID is ignored. Repeat with M_DVALID on cycle 20 → R_ERR = 0.
- Reset mid-EXEC with 3 queued commands → next cycle M_HOLD = M_EXECUTE = 0, C_READY = 1, no R_VALID; a fresh push issues normally.
